// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared types and constants for the stopwatch controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int DIGITS  = 8;
    localparam int DIGIT_W = 4;

    localparam logic [DIGITS*DIGIT_W-1:0] ALL_NINES = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Brief    : Modulo-TICK_DIV counter with count/hold/zero control and a
//            combinational terminal-count strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic count,
    input  logic hold,
    input  logic zero,
    output logic tc
);

    localparam logic [PW-1:0] c_last_count = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_cnt;

    // zero has priority so a clear on a pause edge wins over the held value
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (zero) begin
            r_cnt <= '0;
        end else if (count && !hold) begin
            r_cnt <= (r_cnt == c_last_count) ? '0 : r_cnt + PW'(1);
        end
    end

    assign tc = (r_cnt == c_last_count);

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Run/pause/clear/lap controller for the 8-digit BCD timer.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic        btn_lap,
    input  logic [31:0] cnt_in,
    output logic        one_sec,
    output logic        timer_clr_n,
    output logic        running,
    output logic        lap_hold,
    output logic [31:0] disp,
    output logic        ovf
);

    state_t      r_state;
    logic        r_ss_q;
    logic        r_clr_q;
    logic        r_lap_q;
    logic        r_armed;
    logic        r_one_sec;
    logic        r_clr_n;
    logic        r_lap_hold;
    logic [31:0] r_disp;
    logic        r_ovf;

    logic w_press_ss;
    logic w_press_clr;
    logic w_press_lap;
    logic w_clear;
    logic w_tc;

    // r_armed masks the first cycle after reset so a held button is not a press
    assign w_press_ss  = btn_ss  & ~r_ss_q  & r_armed;
    assign w_press_clr = btn_clr & ~r_clr_q & r_armed;
    assign w_press_lap = btn_lap & ~r_lap_q & r_armed;

    assign w_clear = w_press_clr &
                     (((r_state == IDLE) && !w_press_ss) || (r_state == PAUSE));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PW       (PW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .count (r_state == RUN),
        .hold  (r_state == PAUSE),
        .zero  ((r_state == IDLE) || ((r_state == PAUSE) && w_press_clr)),
        .tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ss_q     <= 1'b0;
            r_clr_q    <= 1'b0;
            r_lap_q    <= 1'b0;
            r_armed    <= 1'b0;
            r_one_sec  <= 1'b0;
            r_clr_n    <= 1'b0;
            r_lap_hold <= 1'b0;
            r_disp     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_ss_q    <= btn_ss;
            r_clr_q   <= btn_clr;
            r_lap_q   <= btn_lap;
            r_one_sec <= (r_state == RUN) && w_tc;
            r_clr_n   <= ~w_clear;

            if (!r_lap_hold) begin
                r_disp <= cnt_in;
            end

            if (w_clear) begin
                r_ovf <= 1'b0;
            end else if (r_one_sec && (cnt_in == ALL_NINES)) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_press_ss) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_press_ss) begin
                        r_state <= PAUSE;
                    end
                    if (w_press_lap) begin
                        r_lap_hold <= ~r_lap_hold;
                    end
                end
                PAUSE: begin
                    if (w_press_clr) begin
                        r_state    <= IDLE;
                        r_lap_hold <= 1'b0;
                    end else begin
                        if (w_press_ss) begin
                            r_state <= RUN;
                        end
                        if (w_press_lap) begin
                            r_lap_hold <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign one_sec     = r_one_sec;
    assign timer_clr_n = r_clr_n;
    assign running     = (r_state == RUN);
    assign lap_hold    = r_lap_hold;
    assign disp        = r_disp;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Scoreboard bench for stopwatch_ctrl with TICK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TD      = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_ss;
    logic        btn_clr;
    logic        btn_lap;
    logic [31:0] cnt_in;
    logic        one_sec;
    logic        timer_clr_n;
    logic        running;
    logic        lap_hold;
    logic [31:0] disp;
    logic        ovf;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_ss      (btn_ss),
        .btn_clr     (btn_clr),
        .btn_lap     (btn_lap),
        .cnt_in      (cnt_in),
        .one_sec     (one_sec),
        .timer_clr_n (timer_clr_n),
        .running     (running),
        .lap_hold    (lap_hold),
        .disp        (disp),
        .ovf         (ovf)
    );

    typedef struct packed {
        logic        running;
        logic        one_sec;
        logic        clr_n;
        logic        lap_hold;
        logic        ovf;
        logic [31:0] disp;
    } exp_t;

    exp_t sb[$];

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";

    // reference model state
    int          m_st    = S_IDLE;
    int          m_pre   = 0;
    bit          m_one   = 1'b0;
    bit          m_clrn  = 1'b0;
    bit          m_lap   = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_armed = 1'b0;
    bit          q_ss    = 1'b0;
    bit          q_clr   = 1'b0;
    bit          q_lap   = 1'b0;
    logic [31:0] m_disp  = '0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit p_ss, p_clr, p_lap, clr_ev;
        if (reset !== 1'b1) begin
            m_st = S_IDLE; m_pre = 0; m_one = 0; m_clrn = 0; m_lap = 0;
            m_ovf = 0; m_armed = 0; q_ss = 0; q_clr = 0; q_lap = 0; m_disp = '0;
            return;
        end
        p_ss   = btn_ss  && !q_ss  && m_armed;
        p_clr  = btn_clr && !q_clr && m_armed;
        p_lap  = btn_lap && !q_lap && m_armed;
        clr_ev = p_clr && ((m_st == S_IDLE && !p_ss) || m_st == S_PAUSE);

        if (clr_ev)                                m_ovf = 0;
        else if (m_one && cnt_in == 32'h99999999)  m_ovf = 1;
        if (!m_lap) m_disp = cnt_in;
        m_one  = (m_st == S_RUN) && (m_pre == TD - 1);
        m_clrn = !clr_ev;

        if (m_st == S_IDLE) begin
            m_pre = 0;
            if (p_ss) m_st = S_RUN;
        end else if (m_st == S_RUN) begin
            m_pre = (m_pre + 1) % TD;
            if (p_lap) m_lap = !m_lap;
            if (p_ss)  m_st = S_PAUSE;
        end else begin
            if (p_clr) begin
                m_st = S_IDLE; m_pre = 0; m_lap = 0;
            end else begin
                if (p_lap) m_lap = 0;
                if (p_ss)  m_st = S_RUN;
            end
        end
        q_ss = btn_ss; q_clr = btn_clr; q_lap = btn_lap; m_armed = 1;
    endtask

    task automatic step(input bit rst_n, input bit ss, input bit clr, input bit lap,
                        input logic [31:0] cnt);
        exp_t e;
        @(negedge clk);
        reset = rst_n; btn_ss = ss; btn_clr = clr; btn_lap = lap; cnt_in = cnt;
        model_edge();
        e.running  = (m_st == S_RUN);
        e.one_sec  = m_one;
        e.clr_n    = m_clrn;
        e.lap_hold = m_lap;
        e.ovf      = m_ovf;
        e.disp     = m_disp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_vec("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_vec("running",     {31'b0, running},     {31'b0, e.running});
            check_vec("one_sec",     {31'b0, one_sec},     {31'b0, e.one_sec});
            check_vec("timer_clr_n", {31'b0, timer_clr_n}, {31'b0, e.clr_n});
            check_vec("lap_hold",    {31'b0, lap_hold},    {31'b0, e.lap_hold});
            check_vec("ovf",         {31'b0, ovf},         {31'b0, e.ovf});
            check_vec("disp",        disp,                 e.disp);
        end
    endtask

    initial begin
        reset = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0; cnt_in = '0;

        phase = "reset";
        step(0, 0, 0, 0, 32'h11111111);
        step(0, 0, 1, 1, 32'h22222222);
        step(0, 1, 0, 0, 32'h33333333);
        check_vec("clr_n_in_reset", {31'b0, timer_clr_n}, 32'd0);
        check_vec("disp_in_reset", disp, 32'd0);
        // ss held across release must not start the watch
        step(1, 1, 0, 0, 32'h00000000);
        check_vec("clr_n_after_release", {31'b0, timer_clr_n}, 32'd1);
        check_vec("held_no_press", {31'b0, running}, 32'd0);
        step(1, 1, 0, 0, 32'h00000000);
        step(1, 0, 0, 0, 32'h00000000);

        phase = "tick";
        step(1, 1, 0, 0, 32'h00000001);
        check_vec("running_on", {31'b0, running}, 32'd1);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 0, 32'(i));
            check_vec("one_sec_cadence", {31'b0, one_sec}, {31'b0, (i % TD) == 0});
        end

        phase = "pause";
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        check_vec("paused", {31'b0, running}, 32'd0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        check_vec("resumed_no_tick", {31'b0, one_sec}, 32'd0);
        step(1, 0, 0, 0, 32'h0);
        check_vec("resumed_tick", {31'b0, one_sec}, 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0);

        phase = "clr_vs_ss";
        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        check_vec("idle", {31'b0, running}, 32'd0);
        check_vec("clr_pulse", {31'b0, timer_clr_n}, 32'd0);
        step(1, 0, 0, 0, 32'h0);
        check_vec("clr_pulse_end", {31'b0, timer_clr_n}, 32'd1);
        check_vec("still_idle", {31'b0, running}, 32'd0);

        phase = "lap";
        step(1, 1, 0, 0, 32'h00001200);
        step(1, 0, 0, 0, 32'h00001233);
        step(1, 0, 0, 1, 32'h00001234);
        check_vec("lap_on", {31'b0, lap_hold}, 32'd1);
        step(1, 0, 0, 1, 32'h00005555);
        step(1, 0, 0, 0, 32'h00006666);
        check_vec("lap_frozen", disp, 32'h00001234);
        step(1, 0, 0, 1, 32'h00007777);
        check_vec("lap_release_edge", disp, 32'h00001234);
        step(1, 0, 0, 0, 32'h00008888);
        check_vec("lap_tracks", disp, 32'h00008888);

        phase = "ovf";
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 32'h99999999);
        check_vec("ovf_set", {31'b0, ovf}, 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'(i));
        check_vec("ovf_sticky", {31'b0, ovf}, 32'd1);
        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        check_vec("ovf_cleared", {31'b0, ovf}, 32'd0);
        step(1, 0, 0, 0, 32'h0);

        phase = "mid_reset";
        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'h00004321);
        step(0, 1, 1, 1, 32'h00000055);
        check_vec("reset_running", {31'b0, running}, 32'd0);
        step(1, 1, 1, 1, 32'h0);
        check_vec("reset_held_btn", {31'b0, running}, 32'd0);

        phase = "random";
        for (int i = 0; i < 200; i++) begin
            step(1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'h99999999 : 32'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
